// File: rtl/alu.sv
// Registered MIPS R-type integer ALU with HI/LO multiply registers.
// out/zero/ovf and HI/LO all update on the rising clock edge; async active-low reset.
module alu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] out,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       shamt,
   input  logic [5:0]       funct,
   output logic             zero,
   output logic             ovf
);

   typedef enum logic [5:0] {
      F_SLL   = 6'h00,
      F_SRL   = 6'h02,
      F_SRA   = 6'h03,
      F_SLLV  = 6'h04,
      F_SRLV  = 6'h06,
      F_SRAV  = 6'h07,
      F_MFHI  = 6'h10,
      F_MTHI  = 6'h11,
      F_MFLO  = 6'h12,
      F_MTLO  = 6'h13,
      F_MULT  = 6'h18,
      F_MULTU = 6'h19,
      F_ADD   = 6'h20,
      F_ADDU  = 6'h21,
      F_SUB   = 6'h22,
      F_SUBU  = 6'h23,
      F_AND   = 6'h24,
      F_OR    = 6'h25,
      F_XOR   = 6'h26,
      F_NOR   = 6'h27,
      F_SLT   = 6'h2A,
      F_SLTU  = 6'h2B
   } funct_e;

   logic [WIDTH-1:0]          out_q, out_d;
   logic                      zero_q, zero_d;
   logic                      ovf_q, ovf_d;
   logic [WIDTH-1:0]          hi_q, hi_d;
   logic [WIDTH-1:0]          lo_q, lo_d;

   funct_e                    op;
   logic [4:0]                var_amt;
   logic signed [WIDTH-1:0]   a_s, b_s;
   logic [WIDTH-1:0]          sum, diff;
   logic                      add_ovf, sub_ovf;
   logic [WIDTH-1:0]          sra_imm, sra_var;
   logic signed [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0]        prod_u;
   logic                      lt_s, lt_u;

   assign op      = funct_e'(funct);
   assign var_amt = a[4:0];
   assign a_s     = a;
   assign b_s     = b;

   assign sum  = a + b;
   assign diff = a - b;
   // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

   assign sra_imm = b_s >>> shamt;
   assign sra_var = b_s >>> var_amt;

   assign prod_s = a_s * b_s;
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   assign lt_s = a_s < b_s;
   assign lt_u = a < b;

   always_comb begin
      out_d = out_q;
      ovf_d = 1'b0;
      hi_d  = hi_q;
      lo_d  = lo_q;
      case (op)
         F_SLL:   out_d = b << shamt;
         F_SRL:   out_d = b >> shamt;
         F_SRA:   out_d = sra_imm;
         F_SLLV:  out_d = b << var_amt;
         F_SRLV:  out_d = b >> var_amt;
         F_SRAV:  out_d = sra_var;
         F_ADD: begin
            out_d = sum;
            ovf_d = add_ovf;
         end
         F_ADDU:  out_d = sum;
         F_SUB: begin
            out_d = diff;
            ovf_d = sub_ovf;
         end
         F_SUBU:  out_d = diff;
         F_AND:   out_d = a & b;
         F_OR:    out_d = a | b;
         F_XOR:   out_d = a ^ b;
         F_NOR:   out_d = ~(a | b);
         F_SLT:   out_d = {{(WIDTH-1){1'b0}}, lt_s};
         F_SLTU:  out_d = {{(WIDTH-1){1'b0}}, lt_u};
         F_MULT: begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
         end
         F_MULTU: begin
            hi_d = prod_u[2*WIDTH-1:WIDTH];
            lo_d = prod_u[WIDTH-1:0];
         end
         F_MFHI:  out_d = hi_q;
         F_MFLO:  out_d = lo_q;
         F_MTHI:  hi_d = a;
         F_MTLO:  lo_d = a;
         default: out_d = '0;
      endcase
      // zero tracks whatever out will hold, including a held value on mult/mt*.
      zero_d = (out_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         zero_q <= 1'b1;
         ovf_q  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         out_q  <= out_d;
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

   assign out  = out_q;
   assign zero = zero_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, async-reset sequence,
// then randomized operations checked against an independent reference model.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] out;
   logic [31:0] a, b;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic        zero, ovf;

   int unsigned checks = 0;
   int unsigned errors = 0;

   alu #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .out   (out),
      .a     (a),
      .b     (b),
      .shamt (shamt),
      .funct (funct),
      .zero  (zero),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [5:0]  f;
      logic [31:0] eo;
      logic        ez;
      logic        ev;
   } vec_t;

   typedef struct {
      logic [31:0] o;
      logic        z;
      logic        v;
      string       name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   // reference model state
   logic [31:0] m_out, m_hi, m_lo;

   function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb,
                               input logic [4:0] vs, input logic [5:0] vf,
                               input logic [31:0] eo, input logic ez, input logic ev);
      vec_t v;
      v.a = va; v.b = vb; v.sh = vs; v.f = vf; v.eo = eo; v.ez = ez; v.ev = ev;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   task automatic compare_pop();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         chk({e.name, " out"},  out,          e.o);
         chk({e.name, " zero"}, {31'b0, zero}, {31'b0, e.z});
         chk({e.name, " ovf"},  {31'b0, ovf},  {31'b0, e.v});
      end
   endtask

   // Drive at the falling edge, result sampled 1 time unit after the next rising edge.
   task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic [4:0] vs,
                        input logic [5:0] vf, input logic [31:0] eo, input logic ez,
                        input logic ev, input string name);
      exp_t e;
      @(negedge clk);
      a = va; b = vb; shamt = vs; funct = vf;
      e.o = eo; e.z = ez; e.v = ev; e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_pop();
   endtask

   task automatic model(input logic [31:0] va, input logic [31:0] vb, input logic [4:0] vs,
                        input logic [5:0] vf, output logic [31:0] eo, output logic ez,
                        output logic ev);
      logic [63:0] ext, p;
      longint      s;
      int          sa, sb_i;
      logic [4:0]  amt;
      sa = va; sb_i = vb;
      ev = 1'b0;
      amt = (vf[2] == 1'b1) ? va[4:0] : vs;
      case (vf)
         6'h00, 6'h04: m_out = vb << amt;
         6'h02, 6'h06: m_out = vb >> amt;
         6'h03, 6'h07: begin
            ext = {{32{vb[31]}}, vb} >> amt;
            m_out = ext[31:0];
         end
         6'h20, 6'h22: begin
            s = (vf == 6'h20) ? longint'(sa) + longint'(sb_i) : longint'(sa) - longint'(sb_i);
            ev = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            m_out = s[31:0];
         end
         6'h21: m_out = va + vb;
         6'h23: m_out = va - vb;
         6'h24: m_out = va & vb;
         6'h25: m_out = va | vb;
         6'h26: m_out = va ^ vb;
         6'h27: m_out = ~va & ~vb;
         6'h2A: m_out = (sa < sb_i) ? 32'd1 : 32'd0;
         6'h2B: m_out = (va < vb) ? 32'd1 : 32'd0;
         6'h18: begin
            p = longint'(sa) * longint'(sb_i);
            m_hi = p[63:32]; m_lo = p[31:0];
         end
         6'h19: begin
            p = {32'b0, va} * {32'b0, vb};
            m_hi = p[63:32]; m_lo = p[31:0];
         end
         6'h10: m_out = m_hi;
         6'h12: m_out = m_lo;
         6'h11: m_hi = va;
         6'h13: m_lo = va;
         default: m_out = 32'd0;
      endcase
      eo = m_out;
      ez = (m_out == 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0]  codes[24];
      logic [31:0] eo, ra, rb;
      logic        ez, ev;
      logic [5:0]  rf;
      logic [4:0]  rs;

      vecs.push_back(mk(32'h1000,     32'h4,        5'd1,  6'h00, 32'h00000008, 1'b0, 1'b0));
      vecs.push_back(mk(32'h1000,     32'h4,        5'd1,  6'h02, 32'h00000002, 1'b0, 1'b0));
      vecs.push_back(mk(32'h1000,     32'h80000000, 5'd4,  6'h03, 32'hF8000000, 1'b0, 1'b0));
      vecs.push_back(mk(32'h1000,     32'h80000000, 5'd4,  6'h02, 32'h08000000, 1'b0, 1'b0));
      vecs.push_back(mk(32'h7FFFFFFF, 32'h1,        5'd0,  6'h20, 32'h80000000, 1'b0, 1'b1));
      vecs.push_back(mk(32'h7FFFFFFF, 32'h1,        5'd0,  6'h21, 32'h80000000, 1'b0, 1'b0));
      vecs.push_back(mk(32'h5,        32'h5,        5'd0,  6'h22, 32'h00000000, 1'b1, 1'b0));
      vecs.push_back(mk(32'hFFFFFFFF, 32'h1,        5'd0,  6'h2A, 32'h00000001, 1'b0, 1'b0));
      vecs.push_back(mk(32'hFFFFFFFF, 32'h1,        5'd0,  6'h2B, 32'h00000000, 1'b1, 1'b0));
      vecs.push_back(mk(32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0,  6'h27, 32'h00000000, 1'b1, 1'b0));
      vecs.push_back(mk(32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0,  6'h25, 32'hFFFFFFFF, 1'b0, 1'b0));
      vecs.push_back(mk(32'hFFFFFFFF, 32'h2,        5'd0,  6'h18, 32'hFFFFFFFF, 1'b0, 1'b0));
      vecs.push_back(mk(32'hFFFFFFFF, 32'h2,        5'd0,  6'h10, 32'hFFFFFFFF, 1'b0, 1'b0));
      vecs.push_back(mk(32'hFFFFFFFF, 32'h2,        5'd0,  6'h12, 32'hFFFFFFFE, 1'b0, 1'b0));
      vecs.push_back(mk(32'hFFFFFFFF, 32'h2,        5'd0,  6'h19, 32'hFFFFFFFE, 1'b0, 1'b0));
      vecs.push_back(mk(32'hFFFFFFFF, 32'h2,        5'd0,  6'h10, 32'h00000001, 1'b0, 1'b0));
      vecs.push_back(mk(32'h00000024, 32'h1,        5'd0,  6'h04, 32'h00000010, 1'b0, 1'b0));
      vecs.push_back(mk(32'h00000024, 32'h1,        5'd0,  6'h3F, 32'h00000000, 1'b1, 1'b0));
      vecs.push_back(mk(32'h0,        32'hDEADBEEF, 5'd0,  6'h00, 32'hDEADBEEF, 1'b0, 1'b0));
      vecs.push_back(mk(32'h0,        32'h80000000, 5'd31, 6'h03, 32'hFFFFFFFF, 1'b0, 1'b0));
      vecs.push_back(mk(32'h0,        32'h80000000, 5'd31, 6'h02, 32'h00000001, 1'b0, 1'b0));
      vecs.push_back(mk(32'h80000000, 32'h1,        5'd0,  6'h22, 32'h7FFFFFFF, 1'b0, 1'b1));
      vecs.push_back(mk(32'h80000000, 32'h1,        5'd0,  6'h23, 32'h7FFFFFFF, 1'b0, 1'b0));
      vecs.push_back(mk(32'h12345678, 32'h0,        5'd0,  6'h11, 32'h7FFFFFFF, 1'b0, 1'b0));
      vecs.push_back(mk(32'h0,        32'h0,        5'd0,  6'h10, 32'h12345678, 1'b0, 1'b0));
      vecs.push_back(mk(32'h0,        32'h0,        5'd0,  6'h13, 32'h12345678, 1'b0, 1'b0));
      vecs.push_back(mk(32'h0,        32'h0,        5'd0,  6'h12, 32'h00000000, 1'b1, 1'b0));
      vecs.push_back(mk(32'h3,        32'h7,        5'd0,  6'h18, 32'h00000000, 1'b1, 1'b0));
      vecs.push_back(mk(32'hFFFFFFE4, 32'h80000000, 5'd9,  6'h07, 32'hF8000000, 1'b0, 1'b0));
      vecs.push_back(mk(32'hFFFFFFE4, 32'h80000000, 5'd9,  6'h06, 32'h08000000, 1'b0, 1'b0));
      vecs.push_back(mk(32'hFF00FF00, 32'h0FF00FF0, 5'd0,  6'h24, 32'h0F000F00, 1'b0, 1'b0));
      vecs.push_back(mk(32'hFF00FF00, 32'h0FF00FF0, 5'd0,  6'h26, 32'hF0F0F0F0, 1'b0, 1'b0));
      vecs.push_back(mk(32'h1,        32'hFFFFFFFF, 5'd0,  6'h2A, 32'h00000000, 1'b1, 1'b0));
      vecs.push_back(mk(32'h1,        32'hFFFFFFFF, 5'd0,  6'h2B, 32'h00000001, 1'b0, 1'b0));
      vecs.push_back(mk(32'h80000000, 32'h80000000, 5'd0,  6'h20, 32'h00000000, 1'b1, 1'b1));
      vecs.push_back(mk(32'h0,        32'h0,        5'd0,  6'h12, 32'h00000015, 1'b0, 1'b0));

      a = '0; b = '0; shamt = '0; funct = 6'h3F;
      rst_n = 1'b0;
      #12;
      chk("reset out",  out,          32'h0);
      chk("reset zero", {31'b0, zero}, 32'h1);
      chk("reset ovf",  {31'b0, ovf},  32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i])
         do_op(vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].f,
               vecs[i].eo, vecs[i].ez, vecs[i].ev, $sformatf("vec%0d", i));

      // Async reset between edges with non-zero HI/LO/out and a pending op on the inputs.
      do_op(32'hAAAA0000, 32'h0, 5'd0, 6'h11, 32'h00000015, 1'b0, 1'b0, "rst_pre mthi");
      do_op(32'h00005555, 32'h0, 5'd0, 6'h13, 32'h00000015, 1'b0, 1'b0, "rst_pre mtlo");
      do_op(32'h1000,     32'h4, 5'd1, 6'h00, 32'h00000008, 1'b0, 1'b0, "rst_pre sll");
      @(negedge clk);
      a = 32'h7FFFFFFF; b = 32'h1; funct = 6'h20;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst out",  out,          32'h0);
      chk("async rst zero", {31'b0, zero}, 32'h1);
      chk("async rst ovf",  {31'b0, ovf},  32'h0);
      @(posedge clk);
      #1;
      chk("rst held out",  out,          32'h0);
      chk("rst held zero", {31'b0, zero}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(32'h0, 32'h0, 5'd0, 6'h10, 32'h0, 1'b1, 1'b0, "post-rst mfhi");
      do_op(32'h0, 32'h0, 5'd0, 6'h12, 32'h0, 1'b1, 1'b0, "post-rst mflo");

      codes = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11,
                6'h12, 6'h13, 6'h18, 6'h19, 6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3E};
      m_out = '0; m_hi = '0; m_lo = '0;
      for (int unsigned n = 0; n < 400; n++) begin
         ra = $urandom();
         rb = $urandom();
         if (n % 7 == 0) ra = {ra[31], {31{~ra[31]}}};
         if (n % 5 == 0) rb = {rb[31], 31'b0} | 32'd1;
         rs = 5'($urandom_range(31, 0));
         rf = codes[$urandom_range(23, 0)];
         model(ra, rb, rs, rf, eo, ez, ev);
         do_op(ra, rb, rs, rf, eo, ez, ev, $sformatf("rand%0d f=%02h", n, rf));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered MIPS R-type integer ALU; executes the operation selected by the 6-bit `funct` field on operands `a` (rs) and `b` (rt).
- Sits in the execute stage of the datapath.
- Result, status flags and the HI/LO multiply registers all update on the rising clock edge.

Parameters:
- WIDTH, 32, operand/result width; all behaviour below is specified for 32.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- out  output  32  registered result.
- a  input  32  operand rs; also the variable shift amount source (a[4:0]).
- b  input  32  operand rt; the value shifted by shift ops.
- shamt  input  5  immediate shift amount for sll/srl/sra.
- funct  input  6  operation select (MIPS funct encoding).
- zero  output  1  registered; 1 when the value loaded into out is 0.
- ovf  output  1  registered signed-overflow flag.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed): out=0, zero=1, ovf=0, HI=0, LO=0. Held while low. First update is on the first rising clk edge after release.
- Latency: a, b, shamt and funct are sampled at a rising edge; the result appears on out/zero/ovf immediately after that same edge (1-cycle registered). There is no handshake; every cycle is a new operation.
- Shifts use b as the value and shift zeros in, except sra/srav, which replicate b[31]:
  - 0x00 sll: b << shamt
  - 0x02 srl: b >> shamt, logical
  - 0x03 sra: b >>> shamt, arithmetic
  - 0x04 sllv, 0x06 srlv, 0x07 srav: same as above with amount a[4:0]; a[31:5] ignored.
- Arithmetic (mod 2^32):
  - 0x20 add, 0x21 addu: a+b
  - 0x22 sub, 0x23 subu: a-b
  - ovf=1 only for add/sub with signed overflow. The wrapped result is still written to out; ovf=0 for every other funct.
- Logic: 0x24 and, 0x25 or, 0x26 xor, 0x27 nor = ~(a|b).
- Compare: 0x2A slt = signed a<b ? 1 : 0; 0x2B sltu = unsigned compare.
- Multiply:
  - 0x18 mult: {HI,LO} = signed a*b, 64-bit.
  - 0x19 multu: unsigned 64-bit product.
  - out is unchanged by mult/multu and zero is recomputed from the held out.
- HI/LO moves:
  - 0x10 mfhi: out=HI
  - 0x12 mflo: out=LO
  - 0x11 mthi: HI=a, out unchanged
  - 0x13 mtlo: LO=a, out unchanged
- A mult followed on the next cycle by mfhi returns the new HI (no hazard).
- Undefined funct codes: out=0, zero=1, ovf=0; HI/LO unchanged.
- Shift amount 0 passes b through unchanged; shift by 31 is legal.
- Reset asserted mid-sequence: immediately clears all state regardless of clk phase; a pending operation is discarded.
- No X propagation from a funct change: out always takes a defined value.

Test Plan:
- Shifts: a=0x1000, b=0x4, shamt=1.
  - funct=0x00 -> out=0x00000008 after next edge.
  - funct=0x02 -> out=0x00000002.
  - b=0x80000000, shamt=4, funct=0x03 -> out=0xF8000000; funct=0x02 -> 0x08000000.
- Add/sub overflow:
  - a=0x7FFFFFFF, b=1, funct=0x20 -> out=0x80000000, ovf=1; funct=0x21 -> same out, ovf=0.
  - a=5, b=5, funct=0x22 -> out=0, zero=1.
- Compare/logic:
  - a=0xFFFFFFFF, b=1: funct=0x2A -> out=1; 0x2B -> out=0.
  - a=0xF0F0F0F0, b=0x0F0F0F0F: 0x27 -> out=0x00000000; 0x25 -> out=0xFFFFFFFF.
- Multiply:
  - a=0xFFFFFFFF, b=2, funct=0x18, then 0x10 -> out=0xFFFFFFFF, then 0x12 -> out=0xFFFFFFFE.
  - Same operands with 0x19 then 0x10 -> out=0x00000001.
- Variable shift and undefined funct:
  - a=0x00000024 (amount 4), b=0x1, funct=0x04 -> out=0x10.
  - funct=0x3F -> out=0, zero=1.
- Reset: drive rst_n low between edges while out=0x8 -> out=0, HI=LO=0 without a clock edge. After release, mfhi -> 0.
